// File: rtl/des_decrypt_iter.sv
// des_decrypt_iter: iterative single-block DES decryptor, one Feistel round per clock.
// Subkeys K16..K1 are produced on the fly by right-rotating the C/D key halves,
// so no subkey storage is needed.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake; ciphertext and key sampled at the accept edge
//   ciphertext, key       [0:63], bit 0 = DES bit 1 (MSB); key includes parity bits
//   out_valid / out_ready output handshake; plaintext held stable while out_valid
//   plaintext             [0:63] decrypted block
//   busy                  high while rounds are running
//   key_err               present only with DES_DEC_PARITY_CHECK_EN: some key byte had
//                         even parity; meaningful only while out_valid is high
//
// Optional feature macro: DES_DEC_PARITY_CHECK_EN
module des_decrypt_iter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [0:63] ciphertext,
    input  logic [0:63] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [0:63] plaintext,
    output logic        busy
`ifdef DES_DEC_PARITY_CHECK_EN
    ,
    output logic        key_err
`endif
);

    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                  10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                  63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                  14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                                  16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                                  44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29,
                                28,29,30,31,32,1};
    localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
    // Sbox1..Sbox8, each stored row-major (row*16 + column).
    localparam int SBOX [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    function automatic logic [0:63] ip_f(input logic [0:63] x);
        logic [0:63] y;
        for (int i = 0; i < 64; i++) y[6'(i)] = x[6'(IP_T[6'(i)] - 1)];
        return y;
    endfunction

    function automatic logic [0:63] fp_f(input logic [0:63] x);
        logic [0:63] y;
        for (int i = 0; i < 64; i++) y[6'(i)] = x[6'(FP_T[6'(i)] - 1)];
        return y;
    endfunction

    function automatic logic [0:55] pc1_f(input logic [0:63] x);
        logic [0:55] y;
        for (int i = 0; i < 56; i++) y[6'(i)] = x[6'(PC1_T[6'(i)] - 1)];
        return y;
    endfunction

    function automatic logic [0:47] pc2_f(input logic [0:55] x);
        logic [0:47] y;
        for (int i = 0; i < 48; i++) y[6'(i)] = x[6'(PC2_T[6'(i)] - 1)];
        return y;
    endfunction

    function automatic logic [0:47] e_f(input logic [0:31] x);
        logic [0:47] y;
        for (int i = 0; i < 48; i++) y[6'(i)] = x[5'(E_T[6'(i)] - 1)];
        return y;
    endfunction

    function automatic logic [0:31] p_f(input logic [0:31] x);
        logic [0:31] y;
        for (int i = 0; i < 32; i++) y[5'(i)] = x[5'(P_T[5'(i)] - 1)];
        return y;
    endfunction

    // Each 6-bit group: outer bits select the row, inner four bits the column.
    function automatic logic [0:31] sbox_f(input logic [0:47] x);
        logic [0:31] y;
        logic [0:5]  g;
        logic [5:0]  idx;
        for (int k = 0; k < 8; k++) begin
            g   = x[6'(6 * k) +: 6];
            idx = {g[0], g[5], g[1:4]};
            y[5'(4 * k) +: 4] = 4'(SBOX[3'(k)][idx]);
        end
        return y;
    endfunction

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t      state;
    logic [0:31] l_q, r_q;
    logic [0:27] c_q, d_q;
    logic [4:0]  cnt;

    logic [0:27] c_rot, d_rot;
    logic [0:31] l_nxt, r_nxt;

    // Decryption walks the key schedule backwards: round 1 uses the PC1 halves
    // unrotated (K16), then right-rotates by 1 at rounds 2, 9, 16 and by 2 elsewhere.
    always_comb begin
        c_rot = c_q;
        d_rot = d_q;
        if (cnt == 5'd2 || cnt == 5'd9 || cnt == 5'd16) begin
            c_rot = {c_q[27], c_q[0:26]};
            d_rot = {d_q[27], d_q[0:26]};
        end else if (cnt != 5'd1) begin
            c_rot = {c_q[26:27], c_q[0:25]};
            d_rot = {d_q[26:27], d_q[0:25]};
        end
        l_nxt = r_q;
        r_nxt = l_q ^ p_f(sbox_f(e_f(r_q) ^ pc2_f({c_rot, d_rot})));
    end

`ifdef DES_DEC_PARITY_CHECK_EN
    logic err_q;

    function automatic logic parity_err_f(input logic [0:63] k);
        logic e;
        e = 1'b0;
        for (int b = 0; b < 8; b++) if (!(^k[6'(8 * b) +: 8])) e = 1'b1;
        return e;
    endfunction
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            plaintext <= '0;
            l_q       <= '0;
            r_q       <= '0;
            c_q       <= '0;
            d_q       <= '0;
            cnt       <= '0;
`ifdef DES_DEC_PARITY_CHECK_EN
            err_q     <= 1'b0;
            key_err   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        {l_q, r_q} <= ip_f(ciphertext);
                        {c_q, d_q} <= pc1_f(key);
                        cnt        <= 5'd1;
                        state      <= ROUND;
                        in_ready   <= 1'b0;
                        busy       <= 1'b1;
`ifdef DES_DEC_PARITY_CHECK_EN
                        err_q      <= parity_err_f(key);
`endif
                    end
                end
                ROUND: begin
                    l_q <= l_nxt;
                    r_q <= r_nxt;
                    c_q <= c_rot;
                    d_q <= d_rot;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd16) begin
                        // Final swap: output is FP(R16 || L16).
                        plaintext <= fp_f({r_nxt, l_nxt});
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
`ifdef DES_DEC_PARITY_CHECK_EN
                        key_err   <= err_q;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
`ifdef DES_DEC_PARITY_CHECK_EN
                        key_err   <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Directed testbench for des_decrypt_iter (standard DES test vectors).
module tb_des_decrypt_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [0:63] ciphertext;
    logic [0:63] key;
    logic        out_valid;
    logic        out_ready;
    logic [0:63] plaintext;
    logic        busy;
`ifdef DES_DEC_PARITY_CHECK_EN
    logic        key_err;
`endif

    int tests = 0;
    int fails = 0;

    localparam logic [0:63] K1 = 64'h133457799BBCDFF1;
    localparam logic [0:63] C1 = 64'h85E813540F0AB405;
    localparam logic [0:63] P1 = 64'h0123456789ABCDEF;
    localparam logic [0:63] K2 = 64'h0E329232EA6D0D73;
    localparam logic [0:63] C2 = 64'h0000000000000000;
    localparam logic [0:63] P2 = 64'h8787878787878787;
    localparam logic [0:63] KP = 64'h123457799BBCDFF1;

    des_decrypt_iter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext),
        .busy       (busy)
`ifdef DES_DEC_PARITY_CHECK_EN
        ,
        .key_err    (key_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    // Present one block for exactly one accept edge.
    task automatic accept(input logic [0:63] ct, input logic [0:63] k);
        @(negedge clk);
        ciphertext = ct;
        key        = k;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges from accept until out_valid (bounded), and cycles with busy high.
    task automatic wait_out(output int lat, output int bcnt);
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcnt++;
        end
    endtask

    task automatic handshake;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        ciphertext = '0; key = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (plaintext !== 64'h0) begin fails++; $display("FAIL reset_plaintext: got %h want 0", plaintext); end
`ifdef DES_DEC_PARITY_CHECK_EN
        tests++; if (key_err !== 1'b0) begin fails++; $display("FAIL reset_key_err: got %b want 0", key_err); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_vector1;
        int lat, bcnt;
        out_ready = 1'b1;
        accept(C1, K1);
        wait_out(lat, bcnt);
        tests++; if (lat != 16) begin fails++; $display("FAIL v1_latency: got %0d want 16", lat); end
        tests++; if (bcnt != 16) begin fails++; $display("FAIL v1_busy_cycles: got %0d want 16", bcnt); end
        tests++; if (plaintext !== P1) begin fails++; $display("FAIL v1_plaintext: got %h want %h", plaintext, P1); end
        handshake();
        tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL v1_release: in_ready %b out_valid %b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_vector2;
        int lat, bcnt;
        out_ready = 1'b1;
        accept(C2, K2);
        wait_out(lat, bcnt);
        tests++; if (plaintext !== P2 || out_valid !== 1'b1) begin
            fails++; $display("FAIL v2_plaintext: got %h vld %b want %h vld 1", plaintext, out_valid, P2);
        end
        handshake();
    endtask

    task automatic test_backpressure;
        int lat, bcnt;
        out_ready = 1'b0;
        accept(C1, K1);
        wait_out(lat, bcnt);
        tests++; if (plaintext !== P1) begin fails++; $display("FAIL bp_plaintext: got %h want %h", plaintext, P1); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            tests++;
            if (out_valid !== 1'b1 || plaintext !== P1 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold cycle %0d: vld %b pt %h rdy %b want 1 %h 0", c, out_valid, plaintext, in_ready, P1);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
        accept(C2, K2);
        wait_out(lat, bcnt);
        tests++; if (lat != 16 || plaintext !== P2) begin
            fails++; $display("FAIL b2b_second: lat %0d pt %h want 16 %h", lat, plaintext, P2);
        end
        handshake();
    endtask

    task automatic test_reset_mid;
        int lat, bcnt, seen;
        out_ready = 1'b1;
        accept(C1, K1);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0 || plaintext !== 64'h0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL midreset_values: vld %b pt %h rdy %b busy %b want 0 0 1 0", out_valid, plaintext, in_ready, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        tests++; if (seen != 0) begin fails++; $display("FAIL midreset_no_pulse: got %0d valid cycles want 0", seen); end
        accept(C2, K2);
        wait_out(lat, bcnt);
        tests++; if (plaintext !== P2) begin fails++; $display("FAIL midreset_next_block: got %h want %h", plaintext, P2); end
        handshake();
    endtask

    task automatic test_in_valid_ignore;
        int lat;
        out_ready = 1'b1;
        accept(C1, K1);
        in_valid = 1'b1;
        lat = 0;
        while (!out_valid && lat < 40) begin
            ciphertext = {$urandom, $urandom};
            key        = {$urandom, $urandom};
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        tests++; if (lat != 16 || plaintext !== P1) begin
            fails++; $display("FAIL ignore_in_valid: lat %0d pt %h want 16 %h", lat, plaintext, P1);
        end
        handshake();
        @(posedge clk);
        #1;
        tests++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL ignore_no_extra_accept: busy %b rdy %b want 0 1", busy, in_ready);
        end
    endtask

`ifdef DES_DEC_PARITY_CHECK_EN
    task automatic test_parity;
        int lat, bcnt;
        out_ready = 1'b1;
        accept(C1, KP);
        wait_out(lat, bcnt);
        tests++; if (plaintext !== P1 || key_err !== 1'b1) begin
            fails++; $display("FAIL parity_bad_key: pt %h err %b want %h 1", plaintext, key_err, P1);
        end
        handshake();
        tests++; if (key_err !== 1'b0) begin fails++; $display("FAIL parity_clear: got %b want 0", key_err); end
        accept(C1, K1);
        wait_out(lat, bcnt);
        tests++; if (plaintext !== P1 || key_err !== 1'b0) begin
            fails++; $display("FAIL parity_good_key: pt %h err %b want %h 0", plaintext, key_err, P1);
        end
        handshake();
    endtask
`endif

    initial begin
        test_reset();
        test_vector1();
        test_vector2();
        test_backpressure();
        test_reset_mid();
        test_in_valid_ignore();
`ifdef DES_DEC_PARITY_CHECK_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
